clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog.sv | 129 ++++++++++++
 tb/tb_clk_div_prog.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable integer clock divider.
//
// Ports
//   clk      input   divider source clock (rising edge; falling edge also used
//                    when CLK_DIV_ODD_DUTY50_EN is defined)
//   rst_n    input   asynchronous active-low reset
//   en       input   run enable; dropping it lets the current period finish
//   div_in   input   requested divide ratio N (W bits, N >= 2)
//   div_load input   one-cycle strobe sampling div_in
//   clk_out  output  divided clock, period N clk cycles
//   tick     output  one-cycle pulse in the cycle starting at each clk_out rise
//   div_cur  output  ratio currently in effect
//   err      output  one-cycle pulse for a rejected load (div_in < 2)
//
// Build option
//   CLK_DIV_ODD_DUTY50_EN  odd N gives exact 50% duty by ORing the phase flop
//                          with a falling-edge retimed copy of it. Undefined:
//                          rising-edge flops only, odd N high for (N+1)/2.
module clk_div_prog #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] div_in,
  input  logic         div_load,
  output logic         clk_out,
  output logic         tick,
  output logic [W-1:0] div_cur,
  output logic         err
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t       state;
  logic [W-1:0] cnt;
  logic [W-1:0] pend_div;
  logic         pend_vld;
  logic         clk_q;

  logic         load_ok;
  logic         load_bad;
  logic         wrap;
  logic [W-1:0] cnt_nxt;
  logic [W:0]   high_len;

  assign load_ok  = div_load && (div_in >= W'(2));
  assign load_bad = div_load && (div_in <  W'(2));
  assign wrap     = (cnt == (div_cur - W'(1)));
  assign cnt_nxt  = cnt + W'(1);

  // Number of whole rising-edge cycles the phase flop stays high per period.
`ifdef CLK_DIV_ODD_DUTY50_EN
  assign high_len = {1'b0, div_cur} >> 1;
`else
  assign high_len = ({1'b0, div_cur} + (W+1)'(1)) >> 1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      clk_q    <= 1'b0;
      tick     <= 1'b0;
      err      <= 1'b0;
      div_cur  <= W'(DEFAULT_DIV);
      pend_div <= '0;
      pend_vld <= 1'b0;
    end else begin
      err  <= load_bad;
      tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt      <= '0;
          clk_q    <= 1'b0;
          pend_vld <= 1'b0;
          // A load held pending across the final wrap is applied here.
          if (load_ok)       div_cur <= div_in;
          else if (pend_vld) div_cur <= pend_div;
          if (en) begin
            state <= ST_RUN;
            clk_q <= 1'b1;
            tick  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (wrap) begin
            cnt <= '0;
            if (pend_vld) div_cur <= pend_div;
            // A load coinciding with the wrap waits for the following wrap.
            pend_vld <= load_ok;
            if (load_ok) pend_div <= div_in;
            if (en) begin
              clk_q <= 1'b1;
              tick  <= 1'b1;
            end else begin
              state <= ST_IDLE;
              clk_q <= 1'b0;
            end
          end else begin
            cnt   <= cnt_nxt;
            clk_q <= ({1'b0, cnt_nxt} < high_len);
            if (load_ok) begin
              pend_div <= div_in;
              pend_vld <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  // Falling-edge copy stretches the high phase by half a cycle for odd N only.
  logic clk_n;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) clk_n <= 1'b0;
    else        clk_n <= clk_q & div_cur[0];
  end

  assign clk_out = clk_q | clk_n;
`else
  assign clk_out = clk_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] div_in;
  logic       div_load;
  logic       clk_out;
  logic       tick;
  logic [7:0] div_cur;
  logic       err;

`ifdef CLK_DIV_ODD_DUTY50_EN
  localparam bit ODD50 = 1'b1;
`else
  localparam bit ODD50 = 1'b0;
`endif

  int vec  = 0;
  int miss = 0;

  logic s_clk  [0:255];
  logic s_tick [0:255];
  int   s_len;

  clk_div_prog #(.W(8), .DEFAULT_DIV(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_cur  (div_cur),
    .err      (err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Expected high time in half-cycles for ratio n.
  function automatic int exp_hi(input int n);
    if (n % 2 == 0) return n;
    return ODD50 ? n : n + 1;
  endfunction

  // Samples clk_out/tick once per half-cycle; even indices follow a rising edge.
  task automatic capture(input int halves);
    @(posedge clk); #1;
    for (int i = 0; i < halves; i++) begin
      s_clk[i]  = clk_out;
      s_tick[i] = tick;
      if (i % 2 == 0) begin @(negedge clk); #1; end
      else            begin @(posedge clk); #1; end
    end
    s_len = halves;
  endtask

  // Period and high time (half-cycles) of the first full pulse in the capture.
  task automatic measure(output int per, output int hi, output int ticks, output int rises);
    int first;
    first = -1; per = -1; hi = 0; ticks = 0; rises = 0;
    for (int i = 1; i < s_len; i++) begin
      if (s_clk[i] && !s_clk[i-1]) begin
        if (i >= 2 && i % 2 == 0) rises++;
        if (first < 0) first = i;
        else if (per < 0) per = i - first;
      end
      if (i >= 2 && i % 2 == 0 && s_tick[i]) ticks++;
    end
    if (first >= 0)
      for (int i = first; i < s_len && s_clk[i]; i++) hi++;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(posedge clk); #1;
      if (tick) seen = 1'b1;
    end
    vec++;
    if (!seen) begin
      miss++;
      $display("FAIL wait_tick: tick=0 after 64 cycles, required a pulse");
    end
  endtask

  task automatic check_wave(input string name, input int n);
    int per, hi, tk, rs;
    capture(6 * n + 8);
    measure(per, hi, tk, rs);
    vec++;
    if (per !== 2 * n) begin
      miss++;
      $display("FAIL %s period: %0d half-cycles, required %0d", name, per, 2 * n);
    end
    vec++;
    if (hi !== exp_hi(n)) begin
      miss++;
      $display("FAIL %s high: %0d half-cycles, required %0d", name, hi, exp_hi(n));
    end
    vec++;
    if (tk !== rs || rs < 2) begin
      miss++;
      $display("FAIL %s ticks: %0d ticks for %0d rises, required equal and >=2", name, tk, rs);
    end
  endtask

  task automatic test_reset();
    #25;
    vec++;
    if (clk_out !== 1'b0) begin miss++; $display("FAIL reset clk_out: %b, required 0", clk_out); end
    vec++;
    if (tick !== 1'b0) begin miss++; $display("FAIL reset tick: %b, required 0", tick); end
    vec++;
    if (err !== 1'b0) begin miss++; $display("FAIL reset err: %b, required 0", err); end
    vec++;
    if (div_cur !== 8'd3) begin miss++; $display("FAIL reset div_cur: %0d, required 3", div_cur); end
  endtask

  task automatic test_start();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    vec++;
    if (clk_out !== 1'b0) begin miss++; $display("FAIL idle clk_out: %b, required 0", clk_out); end
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1;
    vec++;
    if (clk_out !== 1'b1 || tick !== 1'b1) begin
      miss++;
      $display("FAIL start edge: clk_out=%b tick=%b, required 1 1", clk_out, tick);
    end
    check_wave("n3", 3);
  endtask

  task automatic test_load_running();
    wait_tick();
    @(posedge clk); #1;
    div_load = 1'b1; div_in = 8'd5;
    @(posedge clk); #1;
    div_load = 1'b0;
    vec++;
    if (div_cur !== 8'd3 || clk_out !== 1'b0) begin
      miss++;
      $display("FAIL load pending: div_cur=%0d clk_out=%b, required 3 0", div_cur, clk_out);
    end
    @(posedge clk); #1;
    vec++;
    if (div_cur !== 8'd5 || clk_out !== 1'b1 || tick !== 1'b1) begin
      miss++;
      $display("FAIL load wrap: div_cur=%0d clk_out=%b tick=%b, required 5 1 1", div_cur, clk_out, tick);
    end
    check_wave("n5", 5);
  endtask

  task automatic test_err();
    wait_tick();
    div_load = 1'b1; div_in = 8'd4;
    @(posedge clk); #1;
    div_in = 8'd1;
    @(posedge clk); #1;
    div_load = 1'b0;
    vec++;
    if (err !== 1'b1 || div_cur !== 8'd5) begin
      miss++;
      $display("FAIL err pulse: err=%b div_cur=%0d, required 1 5", err, div_cur);
    end
    @(posedge clk); #1;
    vec++;
    if (err !== 1'b0) begin miss++; $display("FAIL err width: err=%b, required 0", err); end
    @(posedge clk); #1;
    vec++;
    if (div_cur !== 8'd5) begin miss++; $display("FAIL err hold: div_cur=%0d, required 5", div_cur); end
    @(posedge clk); #1;
    vec++;
    if (div_cur !== 8'd4 || tick !== 1'b1) begin
      miss++;
      $display("FAIL err keep pending: div_cur=%0d tick=%b, required 4 1", div_cur, tick);
    end
  endtask

  task automatic test_same_edge();
    wait_tick();
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    div_load = 1'b1; div_in = 8'd6;
    @(posedge clk); #1;
    div_load = 1'b0;
    vec++;
    if (tick !== 1'b1 || div_cur !== 8'd4) begin
      miss++;
      $display("FAIL same-edge wrap: tick=%b div_cur=%0d, required 1 4", tick, div_cur);
    end
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    vec++;
    if (div_cur !== 8'd4) begin miss++; $display("FAIL same-edge hold: div_cur=%0d, required 4", div_cur); end
    @(posedge clk); #1;
    vec++;
    if (div_cur !== 8'd6 || tick !== 1'b1) begin
      miss++;
      $display("FAIL same-edge apply: div_cur=%0d tick=%b, required 6 1", div_cur, tick);
    end
    check_wave("n6", 6);
  endtask

  task automatic test_en_drop();
    int highs;
    wait_tick();
    en = 1'b0;
    @(posedge clk); #1;
    vec++;
    if (clk_out !== 1'b1) begin miss++; $display("FAIL en drop high: clk_out=%b, required 1", clk_out); end
    @(posedge clk); @(posedge clk); #1;
    vec++;
    if (clk_out !== 1'b0) begin miss++; $display("FAIL en drop low: clk_out=%b, required 0", clk_out); end
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      if (clk_out !== 1'b0 || tick !== 1'b0) highs++;
      @(posedge clk); #1;
    end
    vec++;
    if (highs !== 0) begin miss++; $display("FAIL en drop idle: %0d active samples, required 0", highs); end
  endtask

  task automatic test_idle_load();
    div_load = 1'b1; div_in = 8'd4;
    @(posedge clk); #1;
    div_load = 1'b0;
    vec++;
    if (div_cur !== 8'd4 || clk_out !== 1'b0) begin
      miss++;
      $display("FAIL idle load: div_cur=%0d clk_out=%b, required 4 0", div_cur, clk_out);
    end
    en = 1'b1;
    @(posedge clk); #1;
    vec++;
    if (clk_out !== 1'b1 || tick !== 1'b1) begin
      miss++;
      $display("FAIL idle restart: clk_out=%b tick=%b, required 1 1", clk_out, tick);
    end
    check_wave("n4", 4);
  endtask

  task automatic test_reset_mid_high();
    wait_tick();
    #5 rst_n = 1'b0;
    #1;
    vec++;
    if (clk_out !== 1'b0 || tick !== 1'b0 || div_cur !== 8'd3) begin
      miss++;
      $display("FAIL async reset: clk_out=%b tick=%b div_cur=%0d, required 0 0 3", clk_out, tick, div_cur);
    end
    @(posedge clk); #1;
    vec++;
    if (clk_out !== 1'b0) begin miss++; $display("FAIL reset held: clk_out=%b, required 0", clk_out); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    vec++;
    if (clk_out !== 1'b1 || tick !== 1'b1) begin
      miss++;
      $display("FAIL reset restart: clk_out=%b tick=%b, required 1 1", clk_out, tick);
    end
    check_wave("n3 after reset", 3);
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    div_in   = 8'd0;
    div_load = 1'b0;
    test_reset();
    test_start();
    test_load_running();
    test_err();
    test_same_edge();
    test_en_drop();
    test_idle_load();
    test_reset_mid_high();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
